// File: rtl/evb_pkg.sv
// Shared definitions for the EVB result collector: widths, reset constants,
// the log2 helper and the layout of one FIFO entry.
package evb_pkg;

  localparam int EVB_RES_W = 32;

  // Pending status word reset value (all ones means "no status yet").
  localparam logic [31:0] EVB_STATUS_RST = 32'hFFFF_FFFF;

  // Ceiling log2, usable in constant expressions for pointer/count widths.
  function automatic int evb_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // One FIFO entry, MSB first: {result, status, last}.
  typedef struct packed {
    logic [EVB_RES_W-1:0] result;
    logic [EVB_RES_W-1:0] status;
    logic                 last;
  } evb_entry_t;

endpackage

// File: rtl/evb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is read
// combinationally from registered storage. A push into a full FIFO is only
// taken when a pop happens in the same cycle; otherwise it is ignored and
// the caller is expected to flag the loss.
module evb_sync_fifo
  import evb_pkg::*;
#(
  parameter int WIDTH = 2 * EVB_RES_W + 1,
  parameter int DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          din_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [evb_log2(DEPTH):0]  count_o
);

  localparam int AW = evb_log2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/evb_result_collector.sv
// Collects per-point results from the block evaluator, holds the newest one
// in a pending register until it is known whether it ends the block, then
// commits it to an output FIFO tagged with a last flag.
// Stream handshake: an entry transfers on every clk edge where
// out_valid && out_ready; while out_valid=1 and out_ready=0 the head entry
// (out_result/out_status/out_last) is held unchanged.
// The evaluator cannot be stalled, so lost commits and malformed pulse
// sequences are reported through sticky flags instead of backpressure.
module evb_result_collector
  import evb_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int RES_W = EVB_RES_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_evp,
  input  logic [RES_W-1:0]         result,
  input  logic [RES_W-1:0]         status,
  input  logic                     done_evb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RES_W-1:0]         out_result,
  output logic [RES_W-1:0]         out_status,
  output logic                     out_last,
  output logic [evb_log2(DEPTH):0] fifo_count,
  output logic                     idle,
  output logic [15:0]              blocks_done,
  output logic                     overflow,
  output logic                     proto_err,
  input  logic                     clr_flags
);

  localparam int EW = 2 * RES_W + 1;

  logic [RES_W-1:0] pend_result_q, pend_result_d;
  logic [RES_W-1:0] pend_status_q, pend_status_d;
  logic             pend_valid_q, pend_valid_d;
  logic [15:0]      blocks_q, blocks_d;
  logic             overflow_q, overflow_d;
  logic             proto_err_q, proto_err_d;

  logic             evb_only;
  logic             commit;
  logic             commit_last;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    fifo_dout;

  // A coincident done_evb is ignored, so only a lone done_evb closes a block.
  assign evb_only    = done_evb && !done_evp;
  assign commit      = pend_valid_q && (done_evp || done_evb);
  assign commit_last = evb_only;
  assign pop         = out_valid && out_ready;

  evb_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (commit),
    .din_i   ({pend_result_q, pend_status_q, commit_last}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid   = !fifo_empty;
  assign out_result  = fifo_dout[EW-1 -: RES_W];
  assign out_status  = fifo_dout[RES_W:1];
  // Storage is unreset, so the last flag is masked while nothing is valid.
  assign out_last    = out_valid && fifo_dout[0];
  assign idle        = fifo_empty && !pend_valid_q;
  assign blocks_done = blocks_q;
  assign overflow    = overflow_q;
  assign proto_err   = proto_err_q;

  // Event handling: pending register, block counter and sticky error flags.
  always_comb begin
    pend_result_d = pend_result_q;
    pend_status_d = pend_status_q;
    pend_valid_d  = pend_valid_q;
    blocks_d      = blocks_q;
    overflow_d    = overflow_q;
    proto_err_d   = proto_err_q;

    if (clr_flags) begin
      overflow_d  = 1'b0;
      proto_err_d = 1'b0;
    end

    if (done_evp) begin
      pend_result_d = result;
      pend_status_d = status;
      pend_valid_d  = 1'b1;
      if (done_evb) proto_err_d = 1'b1;
    end else if (done_evb) begin
      if (pend_valid_q) begin
        pend_valid_d = 1'b0;
        // A dropped last entry still closes its block.
        blocks_d     = blocks_q + 16'd1;
      end else begin
        proto_err_d  = 1'b1;
      end
    end

    if (commit && fifo_full && !pop) overflow_d = 1'b1;
  end

  // Collector state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_result_q <= '0;
      pend_status_q <= RES_W'(EVB_STATUS_RST);
      pend_valid_q  <= 1'b0;
      blocks_q      <= '0;
      overflow_q    <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      pend_result_q <= pend_result_d;
      pend_status_q <= pend_status_d;
      pend_valid_q  <= pend_valid_d;
      blocks_q      <= blocks_d;
      overflow_q    <= overflow_d;
      proto_err_q   <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_evb_result_collector.sv
// Bench for evb_result_collector: directed scenarios followed by random
// pulse traffic, all checked against a queue-based reference model.
module tb_evb_result_collector;
  import evb_pkg::*;

  localparam int DEPTH = 4;
  localparam int RES_W = 32;
  localparam int W     = 2 * RES_W + 1;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             done_evp = 1'b0;
  logic [RES_W-1:0] result = '0;
  logic [RES_W-1:0] status = '0;
  logic             done_evb = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RES_W-1:0] out_result;
  logic [RES_W-1:0] out_status;
  logic             out_last;
  logic [2:0]       fifo_count;
  logic             idle;
  logic [15:0]      blocks_done;
  logic             overflow;
  logic             proto_err;
  logic             clr_flags = 1'b0;

  evb_result_collector #(.DEPTH(DEPTH), .RES_W(RES_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .done_evp    (done_evp),
    .result      (result),
    .status      (status),
    .done_evb    (done_evb),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_status  (out_status),
    .out_last    (out_last),
    .fifo_count  (fifo_count),
    .idle        (idle),
    .blocks_done (blocks_done),
    .overflow    (overflow),
    .proto_err   (proto_err),
    .clr_flags   (clr_flags)
  );

  // Scoreboard: expected FIFO contents plus the rest of the visible state.
  logic [W-1:0]     exp_q[$];
  logic [RES_W:0]   got_q[$];     // {result, last} of every accepted entry
  logic [RES_W-1:0] m_res, m_st;
  bit               m_pv;
  logic [15:0]      m_blocks;
  bit               m_ovf, m_perr;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    evb_entry_t e;
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("fifo_count", fifo_count, exp_q.size());
    chk("idle", idle, (exp_q.size() == 0) && !m_pv);
    chk("blocks_done", blocks_done, m_blocks);
    chk("overflow", overflow, m_ovf);
    chk("proto_err", proto_err, m_perr);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("out_result", out_result, e.result);
      chk("out_status", out_status, e.status);
      chk("out_last", out_last, e.last);
    end else begin
      chk("out_last_idle", out_last, 0);
    end
  endtask

  // Reference model: what one clock edge does to the collector's state.
  task automatic model_edge(input bit evp, input bit evb, input logic [RES_W-1:0] res,
                            input logic [RES_W-1:0] st, input bit rdy, input bit clr);
    bit pop, commit, clast, perr, ovf;
    pop    = rdy && (exp_q.size() > 0);
    commit = m_pv && (evp || evb);
    clast  = !evp;
    perr   = (evp && evb) || (evb && !evp && !m_pv);
    ovf    = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (commit) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_res, m_st, clast});
      else ovf = 1'b1;
      if (clast) m_blocks = m_blocks + 16'd1;
    end
    if (evp) begin
      m_res = res;
      m_st  = st;
      m_pv  = 1'b1;
    end else if (evb) begin
      m_pv = 1'b0;
    end
    m_ovf  = ovf  ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_perr = perr ? 1'b1 : (clr ? 1'b0 : m_perr);
  endtask

  // Driver: one clock cycle with the given inputs, checking before the edge.
  task automatic step(input bit evp, input bit evb, input logic [RES_W-1:0] res,
                      input logic [RES_W-1:0] st, input bit rdy, input bit clr);
    done_evp  = evp;
    done_evb  = evb;
    result    = res;
    status    = st;
    out_ready = rdy;
    clr_flags = clr;
    #1;
    check_outputs();
    if (out_valid && out_ready) got_q.push_back({out_result, out_last});
    @(posedge clk);
    #1;
    model_edge(evp, evb, res, st, rdy, clr);
    done_evp  = 1'b0;
    done_evb  = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic evp_s(input logic [RES_W-1:0] res, input bit rdy);
    step(1, 0, res, res ^ 32'h5A5A_0000, rdy, 0);
  endtask

  task automatic idle_s(input bit rdy);
    step(0, 0, '0, '0, rdy, 0);
  endtask

  task automatic evb_s(input bit rdy);
    step(0, 1, '0, '0, rdy, 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    done_evp  = 1'b0;
    done_evb  = 1'b0;
    clr_flags = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    m_pv     = 1'b0;
    m_blocks = '0;
    m_ovf    = 1'b0;
    m_perr   = 1'b0;
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [RES_W-1:0] res, input bit last);
    if (idx < got_q.size()) chk(tag, got_q[idx], {res, last});
    else chk(tag, {RES_W + 1{1'b1}}, {res, last});
  endtask

  initial begin
    int evps_in_blk, since_evp, r;
    bit rdy;

    // Reset state
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_idle", idle, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_blocks", blocks_done, 0);
    chk("rst_flags", {overflow, proto_err}, 0);

    // Single block of three results, consumer always ready
    evp_s(10, 1); evp_s(20, 1); evp_s(30, 1);
    idle_s(1); idle_s(1); evb_s(1);
    repeat (4) idle_s(1);
    chk("blk_n", got_q.size(), 3);
    chk_got("blk_e0", 0, 10, 0);
    chk_got("blk_e1", 1, 20, 0);
    chk_got("blk_e2", 2, 30, 1);
    chk("blk_done", blocks_done, 1);
    chk("blk_idle", idle, 1);

    // Backpressure: consumer stalled until five cycles after done_evb
    do_reset();
    evp_s(10, 0); evp_s(20, 0); evp_s(30, 0);
    idle_s(0); idle_s(0); evb_s(0);
    repeat (5) idle_s(0);
    chk("bp_count", fifo_count, 3);
    chk("bp_head", out_result, 10);
    repeat (3) idle_s(1);
    chk("bp_n", got_q.size(), 3);
    chk_got("bp_e0", 0, 10, 0);
    chk_got("bp_e1", 1, 20, 0);
    chk_got("bp_e2", 2, 30, 1);
    idle_s(1);

    // Overflow: six results into a four-entry FIFO with no consumer
    do_reset();
    for (int i = 1; i <= 6; i++) evp_s(i, 0);
    idle_s(0); idle_s(0); evb_s(0); idle_s(0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_blocks", blocks_done, 1);
    step(0, 0, '0, '0, 0, 1);
    chk("ovf_clr", overflow, 0);
    repeat (5) idle_s(1);
    chk("ovf_n", got_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_got("ovf_e", i, i + 1, 0);

    // Protocol errors
    do_reset();
    evb_s(1); idle_s(1);
    chk("perr_lone", proto_err, 1);
    chk("perr_lone_cnt", fifo_count, 0);
    step(0, 0, '0, '0, 1, 1);
    chk("perr_clr", proto_err, 0);
    step(1, 1, 77, 7, 1, 0); idle_s(1);
    chk("perr_coinc", proto_err, 1);
    chk("perr_pend", idle, 0);
    chk("perr_cnt", fifo_count, 0);
    evb_s(1); idle_s(1); idle_s(1);
    chk("perr_n", got_q.size(), 1);
    chk_got("perr_e0", 0, 77, 1);

    // Reset in the middle of a block
    do_reset();
    evp_s(5, 1); evp_s(6, 1);
    do_reset();
    idle_s(1); evb_s(1); idle_s(1);
    chk("mid_perr", proto_err, 1);
    chk("mid_cnt", fifo_count, 0);
    chk("mid_blocks", blocks_done, 0);
    chk("mid_idle", idle, 1);

    // Back-to-back blocks
    do_reset();
    evp_s(1, 1); evp_s(2, 1); idle_s(1); evb_s(1);
    evp_s(3, 1); evp_s(4, 1); idle_s(1); evb_s(1);
    idle_s(1); idle_s(1);
    chk("b2b_n", got_q.size(), 4);
    chk_got("b2b_e0", 0, 1, 0);
    chk_got("b2b_e1", 1, 2, 1);
    chk_got("b2b_e2", 2, 3, 0);
    chk_got("b2b_e3", 3, 4, 1);
    chk("b2b_blocks", blocks_done, 2);

    // Random traffic against the model
    do_reset();
    evps_in_blk = 0;
    since_evp   = 0;
    rdy         = 1'b1;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 7) == 0) rdy = !rdy;
      if (r < 3) begin
        step(1, 1, $urandom, $urandom, rdy, $urandom_range(0, 19) == 0);
        evps_in_blk++;
        since_evp = 0;
      end else if (evps_in_blk > 0 && since_evp >= 2 && (r < 30 || evps_in_blk >= 4)) begin
        step(0, 1, '0, '0, rdy, $urandom_range(0, 19) == 0);
        evps_in_blk = 0;
        since_evp++;
      end else if (r < 70) begin
        step(1, 0, $urandom, $urandom, rdy, $urandom_range(0, 19) == 0);
        evps_in_blk++;
        since_evp = 0;
      end else begin
        step(0, 0, '0, '0, rdy, $urandom_range(0, 19) == 0);
        since_evp++;
      end
    end
    repeat (8) idle_s(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
